// File: rtl/hc_pkg.sv
// Shared types and default sizing for the host-copy loopback blocks.
package hc_pkg;

  localparam int DEFAULT_LINE_WIDTH  = 512;
  localparam int DEFAULT_ADDR_WIDTH  = 42;
  localparam int DEFAULT_COUNT_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH  = 16;

  typedef logic [DEFAULT_LINE_WIDTH-1:0]  t_line;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0]  t_line_addr;
  typedef logic [DEFAULT_COUNT_WIDTH-1:0] t_line_count;

  typedef enum logic [1:0] {IDLE, RUN, DONE} loopback_state_e;

endpackage

// File: rtl/loopback_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module loopback_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately left unreset; the empty gate on head hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/loopback_stream.sv
// Streams a configured run of cache lines from src to dst through a credit-limited FIFO,
// optionally XOR-ing each line on the way through.
module loopback_stream
  import hc_pkg::*;
#(
  parameter int LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   finish,
  input  logic [ADDR_WIDTH-1:0]  cfg_src,
  input  logic [ADDR_WIDTH-1:0]  cfg_dst,
  input  logic [COUNT_WIDTH-1:0] cfg_num_lines,
  input  logic [LINE_WIDTH-1:0]  cfg_xor,
  output logic                   rd_req_valid,
  output logic [ADDR_WIDTH-1:0]  rd_req_addr,
  input  logic                   rd_req_ready,
  input  logic                   rd_rsp_valid,
  input  logic [LINE_WIDTH-1:0]  rd_rsp_data,
  output logic                   wr_req_valid,
  output logic [ADDR_WIDTH-1:0]  wr_req_addr,
  output logic [LINE_WIDTH-1:0]  wr_req_data,
  input  logic                   wr_req_ready,
  input  logic                   wr_rsp_valid
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  loopback_state_e state;
  loopback_state_e state_next;

  logic [ADDR_WIDTH-1:0]  src_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [LINE_WIDTH-1:0]  xor_q;
  logic [COUNT_WIDTH-1:0] num_q;
  logic [COUNT_WIDTH-1:0] rd_sent;
  logic [COUNT_WIDTH-1:0] rd_received;
  logic [COUNT_WIDTH-1:0] wr_sent;
  logic [COUNT_WIDTH-1:0] wr_acked;
  logic                   finish_q;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCW-1:0]         fifo_count;
  logic [LINE_WIDTH-1:0]  fifo_head;

  logic [COUNT_WIDTH:0]   in_flight;
  logic                   run;
  logic                   launch;
  logic                   rd_fire;
  logic                   wr_fire;
  logic                   ack_take;

  assign run    = (state == RUN);
  assign launch = (state == IDLE) && start;

  // Lines requested but not yet written; this bound keeps the FIFO from ever overflowing.
  assign in_flight = {1'b0, rd_sent - rd_received} + (COUNT_WIDTH+1)'(fifo_count);

  assign rd_req_valid = run && (rd_sent < num_q) &&
                        (in_flight < (COUNT_WIDTH+1)'(FIFO_DEPTH));
  assign rd_req_addr  = rd_req_valid ? src_q + ADDR_WIDTH'(rd_sent) : '0;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  assign fifo_push    = run && rd_rsp_valid;
  assign wr_req_valid = run && !fifo_empty;
  assign wr_fire      = wr_req_valid && wr_req_ready;
  assign fifo_pop     = wr_fire;
  assign wr_req_addr  = wr_req_valid ? dst_q + ADDR_WIDTH'(wr_sent) : '0;
  assign wr_req_data  = wr_req_valid ? fifo_head : '0;

  assign ack_take = run && wr_rsp_valid && (wr_acked != num_q);
  assign finish   = finish_q;

  loopback_fifo #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rd_rsp_data ^ xor_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (cfg_num_lines == '0) ? DONE : RUN;
      RUN:     if (wr_acked == num_q) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Configuration is captured once at launch so cfg changes mid-run are harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      xor_q       <= '0;
      num_q       <= '0;
      rd_sent     <= '0;
      rd_received <= '0;
      wr_sent     <= '0;
      wr_acked    <= '0;
      finish_q    <= 1'b0;
    end else begin
      if (launch) begin
        src_q       <= cfg_src;
        dst_q       <= cfg_dst;
        xor_q       <= cfg_xor;
        num_q       <= cfg_num_lines;
        rd_sent     <= '0;
        rd_received <= '0;
        wr_sent     <= '0;
        wr_acked    <= '0;
      end else begin
        if (rd_fire)   rd_sent     <= rd_sent + 1'b1;
        if (fifo_push) rd_received <= rd_received + 1'b1;
        if (wr_fire)   wr_sent     <= wr_sent + 1'b1;
        if (ack_take)  wr_acked    <= wr_acked + 1'b1;
      end
      finish_q <= (state == DONE) && start;
    end
  end

  push_while_full: assert property (@(posedge clk) disable iff (!reset)
                                    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_loopback_stream.sv
// Randomised bench for loopback_stream: a memory/ack responder plus a line-counting
// reference model checked against every DUT output on every cycle.
module tb_loopback_stream;

  localparam int LW    = 512;
  localparam int AW    = 42;
  localparam int CW    = 32;
  localparam int DEPTH = 16;

  typedef hc_pkg::t_line      t_line;
  typedef hc_pkg::t_line_addr t_line_addr;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          finish;
  t_line_addr    cfg_src = '0;
  t_line_addr    cfg_dst = '0;
  logic [CW-1:0] cfg_num_lines = '0;
  t_line         cfg_xor = '0;
  logic          rd_req_valid;
  t_line_addr    rd_req_addr;
  logic          rd_req_ready = 1'b0;
  logic          rd_rsp_valid = 1'b0;
  t_line         rd_rsp_data = '0;
  logic          wr_req_valid;
  t_line_addr    wr_req_addr;
  t_line         wr_req_data;
  logic          wr_req_ready = 1'b0;
  logic          wr_rsp_valid = 1'b0;

  loopback_stream #(
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .COUNT_WIDTH (CW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .finish        (finish),
    .cfg_src       (cfg_src),
    .cfg_dst       (cfg_dst),
    .cfg_num_lines (cfg_num_lines),
    .cfg_xor       (cfg_xor),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_ready  (rd_req_ready),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .wr_req_valid  (wr_req_valid),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_req_ready  (wr_req_ready),
    .wr_rsp_valid  (wr_rsp_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [LW-1:0] actual,
                              input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Environment knobs: ready modes 0=always, 1=random, 2=held low.
  int rd_mode = 0;
  int wr_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit pat_index = 1'b0;

  typedef struct { int due; t_line data; } rsp_t;
  rsp_t       rsp_q[$];
  int         ack_q[$];
  t_line_addr rd_log[$];
  t_line_addr wr_addr_log[$];
  t_line      wr_data_log[$];
  int         cyc = 0;
  int         last_ack_cyc = 0;
  int         dut_rd_acc = 0;
  int         dut_wr_acc = 0;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mph_e;
  mph_e              ph = M_IDLE;
  t_line_addr        m_src = '0;
  t_line_addr        m_dst = '0;
  t_line             m_xor = '0;
  logic [CW-1:0]     m_num = '0;
  longint unsigned   m_rd = 0, m_wr = 0, m_rcv = 0, m_ack = 0;
  bit                m_finish = 1'b0;
  bit                e_rd_valid = 1'b0;
  bit                e_wr_valid = 1'b0;

  // Memory contents as a function of line address.
  function automatic t_line pat(input t_line_addr a);
    t_line      d;
    t_line_addr idx;
    idx = a - m_src;
    if (pat_index) d = LW'(idx);
    else for (int k = 0; k < LW/32; k++) d[k*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k);
    return d;
  endfunction

  function automatic logic pick(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 9) < 6);
      default: return 1'b0;
    endcase
  endfunction

  task automatic reset_model();
    ph = M_IDLE;
    m_rd = 0; m_wr = 0; m_rcv = 0; m_ack = 0;
    m_finish = 1'b0; e_rd_valid = 1'b0; e_wr_valid = 1'b0;
  endtask

  // Apply what the last rising edge saw, then derive the outputs now required.
  task automatic advance_and_compare();
    longint unsigned ack_before;
    t_line_addr      ea;
    t_line           ed;
    ack_before = m_ack;
    if (e_rd_valid && rd_req_ready) m_rd++;
    if (e_wr_valid && wr_req_ready) m_wr++;
    if (ph == M_RUN && rd_rsp_valid) m_rcv++;
    if (ph == M_RUN && wr_rsp_valid && m_ack < m_num) m_ack++;
    m_finish = (ph == M_DONE) && start;
    case (ph)
      M_IDLE: if (start) begin
        m_src = cfg_src; m_dst = cfg_dst; m_xor = cfg_xor; m_num = cfg_num_lines;
        m_rd = 0; m_wr = 0; m_rcv = 0; m_ack = 0;
        ph = (cfg_num_lines == 0) ? M_DONE : M_RUN;
      end
      M_RUN:   if (ack_before == m_num) ph = M_DONE;
      default: if (!start) ph = M_IDLE;
    endcase

    e_rd_valid = (ph == M_RUN) && (m_rd < m_num) && (m_rd - m_wr < DEPTH);
    e_wr_valid = (ph == M_RUN) && (m_rcv > m_wr);
    check_output("finish", finish, m_finish);
    check_output("rd_req_valid", rd_req_valid, e_rd_valid);
    ea = e_rd_valid ? m_src + AW'(m_rd) : '0;
    check_output("rd_req_addr", rd_req_addr, ea);
    check_output("wr_req_valid", wr_req_valid, e_wr_valid);
    ea = e_wr_valid ? m_dst + AW'(m_wr) : '0;
    check_output("wr_req_addr", wr_req_addr, ea);
    ea = m_src + AW'(m_wr);
    ed = e_wr_valid ? (pat(ea) ^ m_xor) : '0;
    check_output("wr_req_data", wr_req_data, ed);
  endtask

  task automatic drive_env();
    int due;
    rd_req_ready = pick(rd_mode);
    wr_req_ready = pick(wr_mode);
    if (rd_req_valid === 1'b1 && rd_req_ready) begin
      rsp_t r;
      due = cyc + $urandom_range(lat_min, lat_max);
      if (rsp_q.size() > 0 && rsp_q[$].due >= due) due = rsp_q[$].due + 1;
      r.due = due;
      r.data = pat(rd_req_addr);
      rsp_q.push_back(r);
      rd_log.push_back(rd_req_addr);
      dut_rd_acc++;
    end
    if (wr_req_valid === 1'b1 && wr_req_ready) begin
      due = cyc + $urandom_range(1, 3);
      if (ack_q.size() > 0 && ack_q[$] >= due) due = ack_q[$] + 1;
      ack_q.push_back(due);
      wr_addr_log.push_back(wr_req_addr);
      wr_data_log.push_back(wr_req_data);
      dut_wr_acc++;
    end
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rsp_q[0].data;
      rsp_q.delete(0);
    end
    wr_rsp_valid = 1'b0;
    if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
      wr_rsp_valid = 1'b1;
      last_ack_cyc = cyc;
      ack_q.delete(0);
    end
  endtask

  initial begin : env
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        reset_model();
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0;
        wr_req_ready = 1'b0; wr_rsp_valid = 1'b0;
        ack_q.delete();
        check_output("rst_finish", finish, 0);
        check_output("rst_rd_valid", rd_req_valid, 0);
        check_output("rst_wr_valid", wr_req_valid, 0);
        check_output("rst_rd_addr", rd_req_addr, 0);
        check_output("rst_wr_addr", wr_req_addr, 0);
        check_output("rst_wr_data", wr_req_data, 0);
      end else begin
        advance_and_compare();
        drive_env();
      end
    end
  end

  task automatic set_cfg(input logic [CW-1:0] num, input t_line_addr src, input t_line_addr dst,
                         input t_line x, input int rdm, input int wrm,
                         input int lmin, input int lmax, input bit pidx);
    cfg_num_lines = num; cfg_src = src; cfg_dst = dst; cfg_xor = x;
    rd_mode = rdm; wr_mode = wrm; lat_min = lmin; lat_max = lmax; pat_index = pidx;
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    dut_rd_acc = 0; dut_wr_acc = 0;
  endtask

  // Raise start, wait (bounded) for finish, then drop start and let the block idle.
  task automatic apply_stimulus(input int budget, output int fin_cyc);
    int n;
    start = 1'b1;
    n = 0;
    while (finish !== 1'b1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    fin_cyc = cyc;
    check_output("finish_reached", finish, 1);
    start = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : test
    int   fin;
    int   n;
    t_line x;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) begin @(negedge clk); #1; end

    // Basic copy with index data and a fixed 3-cycle read latency.
    set_cfg(4, 42'h100, 42'h200, '0, 0, 0, 3, 3, 1'b1);
    apply_stimulus(300, fin);
    check_output("basic_rd_count", dut_rd_acc, 4);
    check_output("basic_wr_count", dut_wr_acc, 4);
    if (rd_log.size() == 4 && wr_addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output("basic_rd_addr", rd_log[i], 42'h100 + i);
        check_output("basic_wr_addr", wr_addr_log[i], 42'h200 + i);
        check_output("basic_wr_data", wr_data_log[i], i);
      end
    end
    check_output("basic_finish_after_ack", fin - last_ack_cyc, 3);

    // Zero length: finish two cycles after start, gone one cycle after start drops.
    set_cfg(0, 42'h40, 42'h80, '0, 0, 0, 1, 1, 1'b0);
    start = 1'b1;
    @(negedge clk); #1;
    check_output("zero_finish_c1", finish, 0);
    @(negedge clk); #1;
    check_output("zero_finish_c2", finish, 1);
    start = 1'b0;
    @(negedge clk); #1;
    check_output("zero_finish_drop", finish, 0);
    check_output("zero_rd_count", dut_rd_acc, 0);
    check_output("zero_wr_count", dut_wr_acc, 0);

    // Write backpressure: reads stop once the credit window is full.
    set_cfg(40, 42'h1000, 42'h8000, '0, 0, 2, 3, 3, 1'b0);
    start = 1'b1;
    repeat (50) begin @(negedge clk); #1; end
    check_output("bp_rd_stop", dut_rd_acc, DEPTH);
    check_output("bp_no_writes", dut_wr_acc, 0);
    wr_mode = 0;
    apply_stimulus(500, fin);
    check_output("bp_rd_total", dut_rd_acc, 40);
    check_output("bp_wr_total", dut_wr_acc, 40);

    // XOR transform with random read stalls.
    set_cfg(12, 42'h300, 42'h700, '1, 1, 1, 1, 5, 1'b1);
    apply_stimulus(600, fin);
    check_output("xor_wr_count", dut_wr_acc, 12);
    if (wr_data_log.size() >= 2) begin
      x = '1;
      check_output("xor_data0", wr_data_log[0], x);
      x = ~t_line'(1);
      check_output("xor_data1", wr_data_log[1], x);
    end

    // Source address wraps through zero.
    set_cfg(4, {AW{1'b1}} - 1, 42'h10, '0, 0, 1, 2, 4, 1'b0);
    apply_stimulus(300, fin);
    if (rd_log.size() == 4) begin
      check_output("wrap_a0", rd_log[0], 42'h3FF_FFFF_FFFE);
      check_output("wrap_a1", rd_log[1], 42'h3FF_FFFF_FFFF);
      check_output("wrap_a2", rd_log[2], 0);
      check_output("wrap_a3", rd_log[3], 1);
    end
    check_output("wrap_rd_count", dut_rd_acc, 4);

    // Reset mid-run after five writes, then a short clean run.
    set_cfg(20, 42'h2000, 42'h4000, '0, 1, 1, 1, 4, 1'b0);
    start = 1'b1;
    n = 0;
    while (dut_wr_acc < 5 && n < 400) begin @(negedge clk); #1; n++; end
    check_output("midrst_progress", dut_wr_acc >= 5, 1);
    #1 reset = 1'b0; start = 1'b0;
    #1;
    check_output("midrst_rd_valid", rd_req_valid, 0);
    check_output("midrst_wr_valid", wr_req_valid, 0);
    check_output("midrst_finish", finish, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (20) begin @(negedge clk); #1; end
    set_cfg(2, 42'h500, 42'h600, '0, 0, 0, 2, 2, 1'b1);
    apply_stimulus(200, fin);
    check_output("post_rst_wr_count", dut_wr_acc, 2);
    if (wr_addr_log.size() == 2) begin
      check_output("post_rst_wr_addr1", wr_addr_log[1], 42'h601);
      check_output("post_rst_wr_data1", wr_data_log[1], 1);
    end

    // Fully random runs.
    for (int r = 0; r < 4; r++) begin
      int nl;
      nl = $urandom_range(1, 30);
      for (int k = 0; k < LW/32; k++) x[k*32 +: 32] = $urandom;
      set_cfg(nl, {$urandom, $urandom}, {$urandom, $urandom}, x,
              1, 1, 1, $urandom_range(1, 12), 1'b0);
      apply_stimulus(1500, fin);
      check_output("rand_wr_count", dut_wr_acc, nl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loopback_stream.md
Name: loopback_stream

Overview:
- Parametrised successor to the single-shot loopback engine.
- Streams a runtime-configured number of cache lines from a source buffer to a destination buffer, using an on-chip FIFO and credit-limited read issue.
- Sits between the accelerator control (start/finish) and the host-memory read/write request channels.
- Adds runtime line count, base addresses and an optional XOR data transform.

Parameters:
- LINE_WIDTH, 512, data bits per cache line.
- ADDR_WIDTH, 42, line address width.
- COUNT_WIDTH, 32, width of line counters and cfg_num_lines.
- FIFO_DEPTH, 16, data FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only.
- finish  out  1  transfer complete.
- cfg_src  in  ADDR_WIDTH  source base line address.
- cfg_dst  in  ADDR_WIDTH  destination base line address.
- cfg_num_lines  in  COUNT_WIDTH  lines to copy.
- cfg_xor  in  LINE_WIDTH  XOR mask applied to data; 0 gives pure loopback.
- rd_req_valid  out  1  read request.
- rd_req_addr  out  ADDR_WIDTH  read line address.
- rd_req_ready  in  1  read channel accepts.
- rd_rsp_valid  in  1  read data returned, in request order.
- rd_rsp_data  in  LINE_WIDTH  read data.
- wr_req_valid  out  1  write request.
- wr_req_addr  out  ADDR_WIDTH  write line address.
- wr_req_data  out  LINE_WIDTH  write data.
- wr_req_ready  in  1  write channel accepts.
- wr_rsp_valid  in  1  one write acknowledged.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; all counters 0; FIFO empty.
  - finish=0, rd_req_valid=0, wr_req_valid=0.
  - rd_req_addr, wr_req_addr, wr_req_data = 0.
- Reset mid-transfer: aborts immediately to the reset state. Responses arriving after reset release are ignored while in IDLE.
- Configuration: cfg_* latched on the IDLE->RUN transition; later changes have no effect until the next run.
- IDLE:
  - start==1 and cfg_num_lines!=0 -> RUN next cycle.
  - start==1 and cfg_num_lines==0 -> DONE next cycle; no requests issued.
- RUN:
  - Read issue: rd_req_valid=1 while rd_sent<num_lines and credits available.
  - Credits: rd_outstanding + fifo_count < FIFO_DEPTH, where rd_outstanding = rd_sent - rd_received.
  - Read address: src + rd_sent; ADDR_WIDTH arithmetic, wraps modulo 2^ADDR_WIDTH.
  - Handshake: a request transfers when valid&&ready. Once asserted, valid and addr hold stable until accepted.
  - rd_rsp_valid: pushes rd_rsp_data^cfg_xor into the FIFO the same cycle; rd_received++.
  - Credits guarantee the FIFO never overflows. A push while full is a design error; flag with an assertion.
  - Write issue: wr_req_valid=1 while the FIFO is non-empty. Data is the FIFO head; address is dst + wr_sent.
  - On valid&&ready: pop the FIFO, wr_sent++.
  - Simultaneous push and pop on the same cycle is legal; fifo_count is unchanged.
  - wr_rsp_valid: wr_acked++.
  - Exit: wr_acked==num_lines -> DONE next cycle.
  - Any wr_rsp_valid with wr_acked==num_lines is ignored.
- DONE:
  - finish=1, registered, asserted the cycle after entry.
  - Holds while start==1; start==0 -> IDLE with finish=0 next cycle.
- Latency: first rd_req_valid one cycle after start is sampled. Read-response-to-wr_req_valid latency is 1 cycle (registered FIFO output).
- Throughput: one line per cycle sustained when ready signals are constantly high and read latency < FIFO_DEPTH cycles.
- Counter widths: all COUNT_WIDTH; num_lines up to 2^COUNT_WIDTH-1.

Decomposition:
- Shared hc_pkg:
  - t_line (logic[LINE_WIDTH-1:0]).
  - t_line_addr (logic[ADDR_WIDTH-1:0]).
  - t_line_count.
  - loopback_state_e {IDLE, RUN, DONE}.
- Sub-module: loopback_fifo, a synchronous FIFO with first-word-fall-through output, count, full and empty. Parameters: WIDTH, DEPTH. Same clk and active-low async reset.

Test Plan:
- Basic copy: num_lines=4, src=0x100, dst=0x200, xor=0, readies high, 3-cycle read latency -> reads 0x100..0x103, writes 0x200..0x203 with matching data in order, finish=1 after 4th wr_rsp.
- Zero length: num_lines=0, start=1 -> no rd/wr requests, finish=1 two cycles after start; start=0 -> finish=0 next cycle.
- Backpressure and credit limit: num_lines=40, FIFO_DEPTH=16, wr_req_ready=0 for 50 cycles -> rd_sent stops at 16, no overflow. Release -> all 40 lines written in order, finish asserted.
- XOR mode: cfg_xor all-ones, data pattern i -> written data ~i. Stall rd_req_ready randomly -> rd_req_addr stable while stalled.
- Address wrap: src=2^ADDR_WIDTH-2, num_lines=4 -> read addresses ...FE, ...FF, 0, 1.
- Reset mid-run: assert reset after 5 of 20 writes -> all valids and finish drop immediately. A subsequent 2-line run completes correctly.
